mini_alu_ctrl: RTL and testbench
================================

MINI_ALU_CTRL -- requirements
Module: mini_alu_ctrl

Interface
REQ-001 Parameter: WIDTH, 6, operand/result width in bits.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-006 op  input  3  opcode: 000 pass A, 001 pass B, 010 add, 011 sub, 100 and, 101 or, 110 multiply, 111 illegal.
REQ-007 x1  input  WIDTH  operand A, unsigned.
REQ-008 y1  input  WIDTH  operand B, unsigned.
REQ-009 c1  output  WIDTH  result register.
REQ-010 flag  output  1  carry (add), borrow (sub), overflow (multiply); 0 for all other ops.
REQ-011 err  output  1  set when the completed op was illegal (111).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The block SHALL implement the FSM states IDLE, EXEC, MUL and DONE.
REQ-015 In IDLE with start=1 at edge 0: latch x1, y1 and op; go to MUL if op=110, else to EXEC.
REQ-016 In IDLE with start=0: stay in IDLE; c1, flag and err hold their values.
REQ-017 EXEC: at the next edge, load c1/flag/err from the latched operands and go to DONE; done is high in the cycle after edge 1.
REQ-018 Add: c1 = (A+B) mod 2^WIDTH; flag = carry out of bit WIDTH-1.
REQ-019 Sub: c1 = (A-B) mod 2^WIDTH; flag = 1 iff A<B.
REQ-020 Pass/and/or: c1 = the bitwise or pass result; flag=0.
REQ-021 Illegal op: c1=0, flag=0, err=1; for every legal op, err=0.
REQ-022 MUL: shift-add over WIDTH cycles; an iteration counter runs 0..WIDTH-1, one multiplier bit per edge (edges 1..WIDTH).
REQ-023 MUL: at edge WIDTH, go to DONE; c1 = low WIDTH bits of A*B; flag = 1 iff A*B >= 2^WIDTH.
REQ-024 MUL: done is high in the cycle after edge WIDTH (edge 6 for WIDTH=6).
REQ-025 DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-026 start is ignored in EXEC, MUL and DONE; there is no queuing, and the latched operands are unaffected.
REQ-027 An operation started in IDLE may have start held high continuously; each completion returns to IDLE, and a new op is accepted at the first IDLE edge with start=1.
REQ-028 c1, flag and err SHALL hold from completion until the next completion or reset.
REQ-029 Operand inputs changing during busy SHALL NOT affect the result in progress.

Reset
REQ-030 With reset=1 at an edge: state=IDLE; c1=0, flag=0, err=0, busy=0, done=0; iteration counter and latched operands cleared.
REQ-031 Reset SHALL take priority over start and over any in-progress operation; an aborted operation produces no done pulse.
REQ-032 The first operation after reset deassertion SHALL be accepted at the first edge with reset=0 and start=1.

Verification
REQ-033 Add: A=45, B=30, op=010, start at edge 0 -> done high after edge 1, c1=11, flag=1, err=0.
REQ-034 Sub: A=5, B=9, op=011 -> c1=60, flag=1; then A=9, B=5 -> c1=4, flag=0.
REQ-035 Mul: A=7, B=9, op=110 -> busy for 7 cycles, done high after edge 6 only, c1=63, flag=0; then A=9, B=8 -> c1=8, flag=1.
REQ-036 Illegal op=111, A=63, B=63 -> done after edge 1, c1=0, flag=0, err=1; the next legal op clears err.
REQ-037 Mul A=63, B=63 started, with reset=1 at edge 3 -> IDLE, all outputs 0, no done pulse; then pass A with A=21 -> c1=21.
REQ-038 During a running mul, start=1 with op=010 and new operands -> ignored; the mul result is unchanged and exactly one done pulse occurs.

Source files
------------

// File: rtl/mini_alu_ctrl.sv
// Sequenced mini ALU: pass, add, sub, and, or and shift-add multiply, run by a four-state FSM.
// Latency: done appears one edge after acceptance for single-cycle ops, WIDTH edges after it for multiply.
// Backpressure: none; start is taken only in IDLE, so a request made while busy is dropped.
module mini_alu_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] c1,
    output logic             flag,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_PASS_A = 3'b000;
    localparam logic [2:0] OP_PASS_B = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_MUL    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t             state;
    req_t               req_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   ex_res;
    logic               ex_flag;
    logic               ex_err;
    logic [2*WIDTH-1:0] acc_nxt;

    // Single-cycle datapath, evaluated from the latched request only.
    always_comb begin
        sum     = {1'b0, req_q.a} + {1'b0, req_q.b};
        diff    = {1'b0, req_q.a} - {1'b0, req_q.b};
        ex_res  = '0;
        ex_flag = 1'b0;
        ex_err  = 1'b0;
        case (req_q.op)
            OP_PASS_A: ex_res = req_q.a;
            OP_PASS_B: ex_res = req_q.b;
            OP_ADD: begin
                ex_res  = sum[WIDTH-1:0];
                ex_flag = sum[WIDTH];
            end
            OP_SUB: begin
                ex_res  = diff[WIDTH-1:0];
                ex_flag = diff[WIDTH];
            end
            OP_AND:  ex_res = req_q.a & req_q.b;
            OP_OR:   ex_res = req_q.a | req_q.b;
            default: ex_err = 1'b1;
        endcase
    end

    // One multiplier bit per edge; mcand carries A shifted to the current bit weight.
    always_comb begin
        acc_nxt = acc;
        if (req_q.b[cnt]) begin
            acc_nxt = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req_q <= '0;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            c1    <= '0;
            flag  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        req_q.op <= op;
                        req_q.a  <= x1;
                        req_q.b  <= y1;
                        cnt      <= '0;
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, x1};
                        busy     <= 1'b1;
                        state    <= (op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    c1    <= ex_res;
                    flag  <= ex_flag;
                    err   <= ex_err;
                    done  <= 1'b1;
                    state <= DONE;
                end
                MUL: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        c1    <= acc_nxt[WIDTH-1:0];
                        flag  <= |acc_nxt[2*WIDTH-1:WIDTH];
                        err   <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mini_alu_ctrl.sv
// Directed bench for mini_alu_ctrl: stimulus pushes expected results, a negedge monitor pops on done.
module tb_mini_alu_ctrl;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] x1;
    logic [W-1:0] y1;
    logic [W-1:0] c1;
    logic         flag;
    logic         err;
    logic         busy;
    logic         done;

    mini_alu_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .x1    (x1),
        .y1    (y1),
        .c1    (c1),
        .flag  (flag),
        .err   (err),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c1;
        int flag;
        int err;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;

    task automatic check(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: latency is measured from the first busy cycle to the done cycle.
    int   cyc = 0;
    int   t0 = 0;
    int   busy_run = 0;
    int   exp_run = 0;
    bit   run_pending = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_busy   = 1'b0;
            prev_done   = 1'b0;
            busy_run    = 0;
            run_pending = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                t0       = cyc;
                busy_run = 0;
            end
            if (busy) busy_run++;
            if (!busy && prev_busy && run_pending) begin
                check("busy_len", busy_run, exp_run);
                run_pending = 1'b0;
            end
            if (prev_done) check("done_one_cycle", int'(done), 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("c1", int'(c1), e.c1);
                    check("flag", int'(flag), e.flag);
                    check("err", int'(err), e.err);
                    check("done_latency", cyc - t0, e.lat);
                    exp_run     = e.lat + 1;
                    run_pending = 1'b1;
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic push(input int c, input int f, input int er, input int lat);
        exp_t x;
        x.c1 = c; x.flag = f; x.err = er; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic go(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; x1 = a; y1 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    task automatic run(input logic [2:0] o, input int a, input int b,
                       input int c, input int f, input int er, input int lat, input string name);
        push(c, f, er, lat);
        go(o, W'(a), W'(b));
        wait_done(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; x1 = '0; y1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_c1", int'(c1), 0);
        check("rst_flag", int'(flag), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        run(3'b010, 45, 30, 11, 1, 0, 1, "add");
        run(3'b011, 5, 9, 60, 1, 0, 1, "sub_borrow");
        run(3'b011, 9, 5, 4, 0, 0, 1, "sub");
        run(3'b110, 7, 9, 63, 0, 0, 6, "mul");
        run(3'b110, 9, 8, 8, 1, 0, 6, "mul_ovf");
        run(3'b111, 63, 63, 0, 0, 1, 1, "illegal");
        run(3'b101, 5, 10, 15, 0, 0, 1, "or");
        run(3'b100, 45, 30, 12, 0, 0, 1, "and");
        run(3'b001, 45, 30, 30, 0, 0, 1, "pass_b");

        // Idle with start low: result registers hold while operands wiggle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x1 = W'(i + 1); y1 = W'(i + 7); op = 3'b010;
        end
        check("hold_c1", int'(c1), 30);
        check("hold_busy", int'(busy), 0);

        run(3'b010, 63, 1, 0, 1, 0, 1, "add_wrap");
        run(3'b011, 7, 7, 0, 0, 0, 1, "sub_equal");
        run(3'b110, 8, 8, 0, 1, 0, 6, "mul_64");
        run(3'b110, 63, 1, 63, 0, 0, 6, "mul_by_one");

        // Reset in the middle of a multiply: no done, everything cleared.
        go(3'b110, 6'd63, 6'd63);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_c1", int'(c1), 0);
        check("abort_flag", int'(flag), 0);
        check("abort_err", int'(err), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        run(3'b000, 21, 5, 21, 0, 0, 1, "pass_a_after_reset");

        // A new request during a multiply is dropped; operands change underneath it too.
        push(63, 0, 0, 6);
        go(3'b110, 6'd7, 6'd9);
        @(negedge clk);
        start = 1'b1; op = 3'b010; x1 = 6'd1; y1 = 6'd2;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done("mul_ignore_start");

        // start held high across two back-to-back ops.
        push(11, 1, 0, 1);
        push(60, 1, 0, 1);
        @(negedge clk);
        start = 1'b1; op = 3'b010; x1 = 6'd45; y1 = 6'd30;
        @(negedge clk);
        op = 3'b011; x1 = 6'd5; y1 = 6'd9;
        wait_done("held_first");
        wait_done("held_second");
        start = 1'b0;

        repeat (10) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        check("final_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
